// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU and the iterative multiply/divide unit.
package alu_pkg;

    // ALUFun[5:4] operation classes
    localparam logic [1:0] CLS_ARITH = 2'b00;
    localparam logic [1:0] CLS_LOGIC = 2'b01;
    localparam logic [1:0] CLS_SHIFT = 2'b10;
    localparam logic [1:0] CLS_CMP   = 2'b11;

    localparam logic [3:0] LOG_AND   = 4'b1000;
    localparam logic [3:0] LOG_OR    = 4'b1110;
    localparam logic [3:0] LOG_XOR   = 4'b0110;
    localparam logic [3:0] LOG_NOR   = 4'b0001;
    localparam logic [3:0] LOG_PASSA = 4'b1010;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b11;

    localparam logic [2:0] CMP_NE  = 3'b000;
    localparam logic [2:0] CMP_EQ  = 3'b001;
    localparam logic [2:0] CMP_LT  = 3'b010;
    localparam logic [2:0] CMP_LEZ = 3'b110;
    localparam logic [2:0] CMP_LTZ = 3'b101;
    localparam logic [2:0] CMP_GTZ = 3'b111;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix
    } md_state_e;

    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply / restoring divide on magnitudes, with a final sign-fix cycle.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             wr_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    md_state_e        state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] opb_q;
    logic             div_q;
    logic             sa_q;
    logic             sb_q;
    logic             bzero_q;
    logic             done_q;

    logic             sgn;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] quo_d;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_f;
    logic [WIDTH-1:0]   quo_f;
    logic [WIDTH-1:0]   rem_f;

    always_comb begin
        sgn   = md_is_signed(op_i);
        a_abs = (sgn && a_i[WIDTH-1]) ? -a_i : a_i;
        b_abs = (sgn && b_i[WIDTH-1]) ? -b_i : b_i;
    end

    // acc_q holds the partial product high half / partial remainder; quo_q the low half / quotient.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (quo_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_q, quo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opb_q};
        if (div_q) begin
            if (!div_trial[WIDTH]) begin
                acc_d = div_trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = div_shift[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_d = mul_sum[WIDTH:1];
            quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod   = {acc_q, quo_q};
        prod_f = (sa_q ^ sb_q) ? -prod : prod;
        quo_f  = bzero_q ? '1 : ((sa_q ^ sb_q) ? -quo_q : quo_q);
        rem_f  = sa_q ? -acc_q : acc_q;
        hi_o   = div_q ? rem_f : prod_f[2*WIDTH-1:WIDTH];
        lo_o   = div_q ? quo_f : prod_f[WIDTH-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            quo_q   <= '0;
            opb_q   <= '0;
            div_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bzero_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        div_q   <= op_i[1];
                        sa_q    <= sgn & a_i[WIDTH-1];
                        sb_q    <= sgn & b_i[WIDTH-1];
                        bzero_q <= (b_i == '0);
                        acc_q   <= '0;
                        quo_q   <= a_abs;
                        opb_q   <= b_abs;
                        cnt_q   <= CntW'(WIDTH);
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    acc_q <= acc_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o = (state_q != StIdle);
    assign wr_o   = (state_q == StFix);
    assign done_o = done_q;

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage ALU: combinational ALUFun datapath plus HI/LO registers fed by the iterative md unit.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sign,
    input  logic [5:0]       ALUFun,
    output logic [WIDTH-1:0] S,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    output logic             md_busy,
    output logic             md_done,
    input  logic             hilo_we,
    input  logic             hilo_sel,
    input  logic [WIDTH-1:0] hilo_wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   arith_res;
    logic [WIDTH-1:0]   logic_res;
    logic [WIDTH-1:0]   shift_res;
    logic               zf;
    logic               nf;
    logic               vf;
    logic               lt;
    logic               cmp_bit;

    always_comb begin
        shamt     = A[SHAMT_W-1:0];
        diff      = {1'b0, A} - {1'b0, B};
        arith_res = ALUFun[0] ? (A - B) : (A + B);

        logic_res = '0;
        case (ALUFun[3:0])
            LOG_AND:   logic_res = A & B;
            LOG_OR:    logic_res = A | B;
            LOG_XOR:   logic_res = A ^ B;
            LOG_NOR:   logic_res = ~(A | B);
            LOG_PASSA: logic_res = A;
            default:   logic_res = '0;
        endcase

        shift_res = '0;
        case (ALUFun[1:0])
            SH_SLL:  shift_res = B << shamt;
            SH_SRL:  shift_res = B >> shamt;
            SH_SRA:  shift_res = $signed(B) >>> shamt;
            default: shift_res = '0;
        endcase

        zf = (diff[WIDTH-1:0] == '0);
        nf = diff[WIDTH-1];
        vf = Sign & (A[WIDTH-1] ^ B[WIDTH-1]) & (diff[WIDTH-1] ^ A[WIDTH-1]);
        // Unsigned less-than is the borrow out of A-B
        lt = Sign ? (nf ^ vf) : diff[WIDTH];

        cmp_bit = 1'b0;
        case (ALUFun[3:1])
            CMP_EQ:  cmp_bit = zf;
            CMP_NE:  cmp_bit = ~zf;
            CMP_LT:  cmp_bit = lt;
            CMP_LEZ: cmp_bit = nf | zf;
            CMP_LTZ: cmp_bit = nf;
            CMP_GTZ: cmp_bit = ~(nf | zf);
            default: cmp_bit = 1'b0;
        endcase

        unique case (ALUFun[5:4])
            CLS_ARITH: S = arith_res;
            CLS_LOGIC: S = logic_res;
            CLS_SHIFT: S = shift_res;
            CLS_CMP:   S = {{(WIDTH-1){1'b0}}, cmp_bit};
            default:   S = '0;
        endcase
    end

    logic             md_wr;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv_iter (
        .clk_i   (clk),
        .rst_ni  (reset),
        .start_i (md_start),
        .op_i    (md_op),
        .a_i     (A),
        .b_i     (B),
        .busy_o  (md_busy),
        .done_o  (md_done),
        .wr_o    (md_wr),
        .hi_o    (md_hi),
        .lo_o    (md_lo)
    );

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] lo_d;

    // Direct writes only land when the md unit is idle and not being started.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (md_wr) begin
            hi_d = md_hi;
            lo_d = md_lo;
        end else if (hilo_we && !md_busy && !md_start) begin
            if (hilo_sel) begin
                hi_d = hilo_wdata;
            end else begin
                lo_d = hilo_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv at WIDTH=32 and WIDTH=8.
module tb_alu_muldiv;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B, S, hilo_wdata, hi, lo;
    logic        Sign, md_start, md_busy, md_done, hilo_we, hilo_sel;
    logic [5:0]  ALUFun;
    logic [1:0]  md_op;

    logic [7:0]  A8, B8, S8, wdata8, hi8, lo8;
    logic        Sign8, start8, busy8, done8;
    logic [5:0]  ALUFun8;
    logic [1:0]  op8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.WIDTH(32)) u_dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .Sign(Sign), .ALUFun(ALUFun), .S(S),
        .md_start(md_start), .md_op(md_op), .md_busy(md_busy), .md_done(md_done),
        .hilo_we(hilo_we), .hilo_sel(hilo_sel), .hilo_wdata(hilo_wdata), .hi(hi), .lo(lo)
    );

    alu_muldiv #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .A(A8), .B(B8), .Sign(Sign8), .ALUFun(ALUFun8), .S(S8),
        .md_start(start8), .md_op(op8), .md_busy(busy8), .md_done(done8),
        .hilo_we(1'b0), .hilo_sel(1'b0), .hilo_wdata(wdata8), .hi(hi8), .lo(lo8)
    );

    typedef struct packed {
        logic [5:0]  fun;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
    } vec_t;

    // Starts an op at the next edge, scrambles the inputs, returns edges to md_done (0 = timeout).
    task automatic run_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int edges);
        edges = 0;
        md_op = op; A = a; B = b; Sign = 1'b1; md_start = 1'b1;
        @(posedge clk); #1;
        md_start = 1'b0; A = $urandom; B = $urandom; md_op = 2'($urandom);
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (md_done) begin
                edges = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; md_start = 1'b0; hilo_we = 1'b0; hilo_sel = 1'b0; hilo_wdata = '0;
        Sign = 1'b0; md_op = MD_MULT; A = 32'd1; B = 32'd2; ALUFun = 6'b000000;
        start8 = 1'b0; op8 = MD_MULT; A8 = '0; B8 = '0; Sign8 = 1'b1; ALUFun8 = 6'b000000;
        wdata8 = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin
            errors++; $display("FAIL reset_hilo: got hi=%h lo=%h want 0", hi, lo);
        end
        checks++; if (md_busy !== 1'b0 || md_done !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got busy=%b done=%b want 0", md_busy, md_done);
        end
        checks++; if (S !== 32'd3) begin
            errors++; $display("FAIL reset_comb_s: got %h want 00000003", S);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        vec_t v [21];
        v[0]  = '{6'b000000, 1'b0, 32'd7,        32'd9,        32'd16};
        v[1]  = '{6'b000001, 1'b0, 32'd7,        32'd9,        32'hFFFFFFFE};
        v[2]  = '{6'b011000, 1'b0, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000};
        v[3]  = '{6'b011110, 1'b0, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0};
        v[4]  = '{6'b010110, 1'b0, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0};
        v[5]  = '{6'b010001, 1'b0, 32'd0,        32'd0,        32'hFFFFFFFF};
        v[6]  = '{6'b011010, 1'b0, 32'h00001234, 32'h0000FFFF, 32'h00001234};
        v[7]  = '{6'b010011, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
        v[8]  = '{6'b100000, 1'b0, 32'd4,        32'd1,        32'h00000010};
        v[9]  = '{6'b100001, 1'b0, 32'd4,        32'h80000000, 32'h08000000};
        v[10] = '{6'b100011, 1'b0, 32'd4,        32'h80000000, 32'hF8000000};
        v[11] = '{6'b100010, 1'b0, 32'd4,        32'h80000000, 32'd0};
        v[12] = '{6'b100000, 1'b0, 32'h00000024, 32'd1,        32'h00000010};
        v[13] = '{6'b110010, 1'b0, 32'd5,        32'd5,        32'd1};
        v[14] = '{6'b110000, 1'b0, 32'd5,        32'd5,        32'd0};
        v[15] = '{6'b110101, 1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd0};
        v[16] = '{6'b110101, 1'b0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd1};
        v[17] = '{6'b110101, 1'b1, 32'hFFFFFFFF, 32'd1,        32'd1};
        v[18] = '{6'b111100, 1'b1, 32'd3,        32'd3,        32'd1};
        v[19] = '{6'b111010, 1'b1, 32'd3,        32'd3,        32'd0};
        v[20] = '{6'b111110, 1'b1, 32'd5,        32'd3,        32'd1};
        for (int i = 0; i < 21; i++) begin
            ALUFun = v[i].fun; Sign = v[i].sgn; A = v[i].a; B = v[i].b;
            #1;
            checks++; if (S !== v[i].s) begin
                errors++; $display("FAIL alu_vec%0d: got %h want %h", i, S, v[i].s);
            end
        end
    endtask

    task automatic test_mult();
        int e;
        run_md(MD_MULT, 32'hFFFFFFFD, 32'd5, e);
        checks++; if (e !== 33) begin
            errors++; $display("FAIL mult_latency: got %0d want 33", e);
        end
        checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
            errors++; $display("FAIL mult_neg: got %h_%h want ffffffff_fffffff1", hi, lo);
        end
        run_md(MD_MULTU, 32'hFFFFFFFF, 32'd2, e);
        checks++; if (hi !== 32'd1 || lo !== 32'hFFFFFFFE) begin
            errors++; $display("FAIL multu: got %h_%h want 00000001_fffffffe", hi, lo);
        end
        run_md(MD_MULT, 32'h80000000, 32'h80000000, e);
        checks++; if (hi !== 32'h40000000 || lo !== 32'd0) begin
            errors++; $display("FAIL mult_min: got %h_%h want 40000000_00000000", hi, lo);
        end
    endtask

    task automatic test_div();
        int e;
        run_md(MD_DIV, 32'hFFFFFFF9, 32'd2, e);
        checks++; if (e !== 33) begin
            errors++; $display("FAIL div_latency: got %0d want 33", e);
        end
        checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL div_neg: got lo=%h hi=%h want fffffffd ffffffff", lo, hi);
        end
        run_md(MD_DIVU, 32'd7, 32'd0, e);
        checks++; if (e !== 33 || lo !== 32'hFFFFFFFF || hi !== 32'd7) begin
            errors++; $display("FAIL divu_zero: got e=%0d lo=%h hi=%h want 33 ffffffff 7", e, lo, hi);
        end
        run_md(MD_DIV, 32'hFFFFFFFB, 32'd0, e);
        checks++; if (lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFFB) begin
            errors++; $display("FAIL div_zero_neg: got lo=%h hi=%h want ffffffff fffffffb", lo, hi);
        end
        run_md(MD_DIV, 32'h80000000, 32'hFFFFFFFF, e);
        checks++; if (lo !== 32'h80000000 || hi !== 32'd0) begin
            errors++; $display("FAIL div_min_m1: got lo=%h hi=%h want 80000000 0", lo, hi);
        end
        run_md(MD_DIVU, 32'd100, 32'd7, e);
        checks++; if (lo !== 32'd14 || hi !== 32'd2) begin
            errors++; $display("FAIL divu: got lo=%h hi=%h want e 2", lo, hi);
        end
    endtask

    task automatic test_back_to_back();
        int e = 0;
        int dones = 0;
        logic dropped = 1'b0;
        md_op = MD_MULT; A = 32'd6; B = 32'd7; Sign = 1'b1; md_start = 1'b1;
        @(posedge clk); #1;
        A = 32'd2; B = 32'd2;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (md_done) begin
                e = n;
                break;
            end
            if (!md_busy) dropped = 1'b1;
        end
        md_start = 1'b0;
        checks++; if (e !== 33 || dropped !== 1'b0) begin
            errors++; $display("FAIL held_start: got e=%0d dropped=%b want 33 0", e, dropped);
        end
        checks++; if (hi !== 32'd0 || lo !== 32'd42) begin
            errors++; $display("FAIL held_start_res: got %h_%h want 0_2a", hi, lo);
        end
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (md_done) dones++;
        end
        checks++; if (dones !== 0 || md_busy !== 1'b0) begin
            errors++; $display("FAIL held_start_once: got extra=%0d busy=%b want 0 0", dones, md_busy);
        end
    endtask

    task automatic test_hilo();
        int e = 0;
        hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wdata = 32'h00001111;
        @(posedge clk); #1;
        checks++; if (lo !== 32'h00001111 || hi !== 32'd0) begin
            errors++; $display("FAIL mtlo: got lo=%h hi=%h want 1111 0", lo, hi);
        end
        hilo_sel = 1'b1; hilo_wdata = 32'h00002222;
        @(posedge clk); #1;
        checks++; if (hi !== 32'h00002222 || lo !== 32'h00001111) begin
            errors++; $display("FAIL mthi: got hi=%h lo=%h want 2222 1111", hi, lo);
        end
        hilo_wdata = 32'h0000DEAD;
        md_op = MD_MULTU; A = 32'd3; B = 32'd4; md_start = 1'b1;
        @(posedge clk); #1;
        md_start = 1'b0;
        checks++; if (hi !== 32'h00002222) begin
            errors++; $display("FAIL hilo_vs_start: got hi=%h want 2222", hi);
        end
        repeat (20) @(posedge clk);
        #1;
        checks++; if (hi !== 32'h00002222 || md_busy !== 1'b1) begin
            errors++; $display("FAIL hilo_busy: got hi=%h busy=%b want 2222 1", hi, md_busy);
        end
        hilo_we = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (md_done) begin
                e = 1;
                break;
            end
        end
        checks++; if (e !== 1 || hi !== 32'd0 || lo !== 32'd12) begin
            errors++; $display("FAIL hilo_md_wins: got done=%0d hi=%h lo=%h want 1 0 c", e, hi, lo);
        end
    endtask

    task automatic test_reset_mid();
        int e;
        int dones = 0;
        md_op = MD_MULTU; A = 32'h0000FFFF; B = 32'h0000FFFF; md_start = 1'b1;
        @(posedge clk); #1;
        md_start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (md_busy !== 1'b0 || md_done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++; $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
                               md_busy, md_done, hi, lo);
        end
        reset = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (md_done) dones++;
        end
        checks++; if (dones !== 0) begin
            errors++; $display("FAIL reset_mid_nodone: got %0d dones want 0", dones);
        end
        run_md(MD_DIVU, 32'd100, 32'd7, e);
        checks++; if (e !== 33 || lo !== 32'd14 || hi !== 32'd2) begin
            errors++; $display("FAIL after_reset: got e=%0d lo=%h hi=%h want 33 e 2", e, lo, hi);
        end
    endtask

    task automatic test_width8();
        int e = 0;
        A8 = 8'd4; B8 = 8'h80; ALUFun8 = 6'b100011;
        #1;
        checks++; if (S8 !== 8'hF8) begin
            errors++; $display("FAIL w8_sra: got %h want f8", S8);
        end
        op8 = MD_MULT; A8 = 8'h80; B8 = 8'h80; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; A8 = 8'h11; B8 = 8'h22;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (done8) begin
                e = n;
                break;
            end
        end
        checks++; if (e !== 9 || hi8 !== 8'h40 || lo8 !== 8'h00) begin
            errors++; $display("FAIL w8_mult: got e=%0d hi=%h lo=%h want 9 40 00", e, hi8, lo8);
        end
        e = 0;
        op8 = MD_DIVU; A8 = 8'd200; B8 = 8'd7; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (done8) begin
                e = n;
                break;
            end
        end
        checks++; if (e !== 9 || lo8 !== 8'd28 || hi8 !== 8'd4) begin
            errors++; $display("FAIL w8_divu: got e=%0d lo=%h hi=%h want 9 1c 04", e, lo8, hi8);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mult();
        test_div();
        test_back_to_back();
        test_hilo();
        test_reset_mid();
        test_width8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Parametrised successor to the pipeline's single-cycle ALU. It keeps the same combinational ALUFun datapath (add/sub, logic, shift, compare), generalised to WIDTH bits. It adds an iterative multiply/divide unit with HI/LO registers and a start/busy/done handshake. It sits in the EX stage, and the pipeline stalls on md_busy.

Parameters:
WIDTH, 32, datapath width in bits (power of two, >= 8)
SHAMT_W, $clog2(WIDTH), shift-amount bits taken from A (localparam, derived)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
A  in  WIDTH  operand A (shift amount in A[SHAMT_W-1:0])
B  in  WIDTH  operand B (shifted value)
Sign  in  1  1 = signed compare/overflow and signed md ops
ALUFun  in  6  combinational op select
S  out  WIDTH  combinational ALU result
md_start  in  1  start a multiply/divide (sampled only in IDLE)
md_op  in  2  00 mult, 01 multu, 10 div, 11 divu
md_busy  out  1  unit occupied
md_done  out  1  one-cycle pulse; hi/lo updated this cycle
hilo_we  in  1  direct HI/LO write (mthi/mtlo)
hilo_sel  in  1  0 = LO, 1 = HI
hilo_wdata  in  WIDTH  direct write data
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- S is purely combinational with zero latency, unaffected by clk/reset. The select is ALUFun[5:4]: 00 add/sub, 01 logic, 10 shift, 11 compare.
- Add/sub: ALUFun[0] = 1 gives A-B, otherwise A+B; the result wraps modulo 2^WIDTH.
- Logic (ALUFun[3:0]):
  - 1000 AND
  - 1110 OR
  - 0110 XOR
  - 0001 NOR
  - 1010 pass A
  - any other code gives 0
- Shift (ALUFun[1:0]):
  - 00 SLL B by A[SHAMT_W-1:0]
  - 01 SRL
  - 11 SRA
  - 10 gives 0
- Compare (uses A-B; Z = zero flag, N = sign flag):
  - Result occupies bit 0; upper bits are 0.
  - ALUFun[3:1] codes:
    - 001 eq
    - 000 ne
    - 010 lt
    - 110 A<=0 (N|Z)
    - 101 A<0 (N)
    - 111 A>0 (~(N|Z))
    - any other code gives 0
  - lt is N xor V when Sign = 1, and the borrow (A<B unsigned) when Sign = 0.
  - V (signed overflow) is computed only when Sign = 1.
- MD FSM has three states: IDLE, CALC, FIX.
  - IDLE: when md_start = 1 at a rising edge, latch the operands (absolute values for signed ops), latch md_op, load counter = WIDTH, go to CALC.
  - CALC: one radix-2 shift-add (mult) or restoring-subtract (div) step per edge. Decrement the counter; at 0, go to FIX.
  - FIX: apply sign correction, write hi/lo, assert md_done for exactly this cycle, go to IDLE.
  - md_busy = (state != IDLE).
  - md_done rises WIDTH+1 edges after the start edge; hi/lo are valid in the same cycle.
- Results:
  - mult/multu: {hi,lo} = 2·WIDTH-bit product.
  - div/divu: lo = quotient, hi = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of A.
- Division by zero: same latency, lo = all ones, hi = A.
- Signed MIN / -1: lo = MIN, hi = 0, with no trap.
- md_start while busy is ignored, and operands are not re-latched.
- hilo_we:
  - Writes the selected register at the edge only when state = IDLE and md_start = 0.
  - It is ignored otherwise, so the md result wins.
- A/B/md_op may change freely after the start edge.
- Reset (reset = 0 at an edge): state goes to IDLE; hi, lo, md_busy, md_done go to 0; the counter goes to 0. Reset mid-operation aborts the operation and does not pulse md_done.

Decomposition:
- Shared package alu_pkg holds:
  - ALUFun[5:4] class constants
  - logic/shift/compare codes
  - md_op codes (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU)
  - FSM state enum
- One sub-module, muldiv_iter, contains the FSM, counter, iteration datapath, and sign fix.
- The top level alu_muldiv holds the combinational ALU, the HI/LO registers and the write arbitration.

Test Plan:
- Combinational sweep, WIDTH = 32:
  - A = 7, B = 9, ALUFun = 000001 -> S = 0xFFFFFFFE.
  - A = 4, B = 0x80000000, ALUFun = 100011 -> S = 0xF8000000.
  - Sign = 1, A = 0x7FFFFFFF, B = 0xFFFFFFFF, lt (110101) -> S = 0. This is the overflow case.
- mult, Sign = 1, A = -3, B = 5 -> md_done at edge 33 after start; hi = 0xFFFFFFFF, lo = 0xFFFFFFF1. multu on 0xFFFFFFFF × 2 -> hi = 1, lo = 0xFFFFFFFE.
- div, A = -7, B = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. divu, A = 7, B = 0 -> lo = 0xFFFFFFFF, hi = 7. div, A = 0x80000000, B = -1 -> lo = 0x80000000, hi = 0.
- Handshake:
  - md_start held high through the whole operation -> exactly one md_done, and the result belongs to the first operands.
  - hilo_we during busy -> no effect.
  - hilo_we in IDLE -> value appears on the next cycle.
- Reset asserted at CALC cycle 10 -> next cycle md_busy = 0, hi = lo = 0, no md_done; a new start afterwards completes correctly.
- WIDTH = 8 instance: mult 0x80 × 0x80 signed -> hi = 0x40, lo = 0x00, done at edge 9.
